cpu_stack_wb: RTL

- Final (writeback) stage of the stack CPU pipeline; consumes the 4a outputs of the memory stage.
- Commits each instruction's pop-count and push to the operand stack, a register array indexed by a stack pointer.
- Exports the top two stack entries combinationally to the operand-read stage.
- Registers the branch redirect (kill/target) for fetch and raises a sticky fault on stack overflow or underflow.

---
 rtl/cpu_stack_wb_pkg.sv | 23 ++
 rtl/cpu_stack_regs.sv | 38 +++
 rtl/cpu_stack_wb.sv | 110 +++++++++++
 3 files changed

// File: rtl/cpu_stack_wb_pkg.sv
// rtl/cpu_stack_wb_pkg.sv - shared opcode macros and stack constants for the writeback stage
// Push-select encodings live in the shared opcode macros; the package mirrors the ones used here.

`ifndef UC_PUSHNONE
`define UC_PUSHNONE 3'd0
`endif
`ifndef UC_PUSHALU
`define UC_PUSHALU 3'd1
`endif
`ifndef ST_ENTRY_W
`define ST_ENTRY_W 35
`endif

package cpu_stack_wb_pkg;

  localparam int ST_W = `ST_ENTRY_W;
  localparam logic [2:0] UC_PUSHNONE = `UC_PUSHNONE;

  function automatic logic is_push(input logic [2:0] sel);
    return sel != UC_PUSHNONE;
  endfunction

endpackage

// File: rtl/cpu_stack_regs.sv
// rtl/cpu_stack_regs.sv - operand stack array with TOS/NOS combinational read ports
// Contents are never reset; the read ports mask to zero when sp is too shallow.

module cpu_stack_regs #(
  parameter int DEPTH = 64,
  parameter int SP_W  = 11,
  parameter int W     = 35,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [SP_W-1:0]  sp,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     tos0,
  output logic [W-1:0]     tos1
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    tos0 = '0;
    tos1 = '0;
    if (sp >= SP_W'(1)) begin
      tos0 = mem[IDX_W'(sp - SP_W'(1))];
    end
    if (sp >= SP_W'(2)) begin
      tos1 = mem[IDX_W'(sp - SP_W'(2))];
    end
  end

endmodule

// File: rtl/cpu_stack_wb.sv
// rtl/cpu_stack_wb.sv - stack CPU writeback: stack commit, branch redirect, sticky stack fault
// Optional high-water mark tracking is enabled with CPU_STACK_HWM_EN.

module cpu_stack_wb
  import cpu_stack_wb_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int SP_W  = 11
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            valid_4a,
  input  logic [2:0]      c__to_push_4a,
  input  logic [34:0]     st__to_push_4a,
  input  logic [10:0]     st__to_pop_4a,
  input  logic            kill_4a,
  input  logic [31:0]     branch_target_4a,
  input  logic [31:0]     pc_4a,
  output logic [34:0]     st__tos0,
  output logic [34:0]     st__tos1,
  output logic [SP_W-1:0] st__sp,
  output logic            redirect_5a,
  output logic [31:0]     redirect_pc_5a,
  output logic            fault_5a,
  output logic [31:0]     fault_pc_5a,
  output logic [SP_W-1:0] st__hwm
);

  localparam int IDX_W = $clog2(DEPTH);
  // One bit wider than both sp and the pop count so the subtraction never wraps silently.
  localparam int AW = ((SP_W > 11) ? SP_W : 11) + 1;

  logic [SP_W-1:0] sp_q;
  logic            push;
  logic [AW-1:0]   base_x;
  logic [AW-1:0]   next_x;
  logic            underflow;
  logic            overflow;
  logic            live;
  logic            commit;
  logic            fault_evt;
  logic            redir_take;

  always_comb begin
    push       = is_push(c__to_push_4a);
    base_x     = AW'(sp_q) - AW'(st__to_pop_4a);
    next_x     = base_x + AW'(push);
    underflow  = AW'(st__to_pop_4a) > AW'(sp_q);
    overflow   = !underflow && (next_x > AW'(DEPTH));
    live       = valid_4a && !fault_5a;
    commit     = live && !underflow && !overflow;
    fault_evt  = live && (underflow || overflow);
    redir_take = live && kill_4a;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sp_q           <= '0;
      fault_5a       <= 1'b0;
      fault_pc_5a    <= '0;
      redirect_5a    <= 1'b0;
      redirect_pc_5a <= '0;
    end else begin
      redirect_5a <= redir_take;
      if (redir_take) begin
        redirect_pc_5a <= branch_target_4a;
      end
      if (commit) begin
        sp_q <= next_x[SP_W-1:0];
      end
      if (fault_evt) begin
        fault_5a    <= 1'b1;
        fault_pc_5a <= pc_4a;
      end
    end
  end

  cpu_stack_regs #(
    .DEPTH (DEPTH),
    .SP_W  (SP_W),
    .W     (ST_W)
  ) u_regs (
    .clk   (clk),
    .sp    (sp_q),
    .we    (commit && push),
    .waddr (IDX_W'(base_x)),
    .wdata (st__to_push_4a),
    .tos0  (st__tos0),
    .tos1  (st__tos1)
  );

  assign st__sp = sp_q;

`ifdef CPU_STACK_HWM_EN
  logic [SP_W-1:0] hwm_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      hwm_q <= '0;
    end else if (commit && (next_x > AW'(hwm_q))) begin
      hwm_q <= next_x[SP_W-1:0];
    end
  end

  assign st__hwm = hwm_q;
`else
  assign st__hwm = '0;
`endif

endmodule
